// File: rtl/hub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hub_pkg
// Purpose  : Shared types and defaults for the hub transmit arbiter slice.
//            arb_state_t  - arbiter FSM states
//            HUB_DATA_W   - default byte width (matches Transmitter din)
//            HUB_N_PORTS  - default number of requesting hub ports
// Revision : 1.0 - initial release
// ============================================================================
package hub_pkg;

  localparam int HUB_DATA_W  = 8;
  localparam int HUB_N_PORTS = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_HIGH = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/hub_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : hub_tx_arbiter_if
// Purpose  : Bundles the per-port byte handshake and the Transmitter pins.
// Ports    : req_valid [N_PORTS]         port i has a byte pending
//            req_data  [N_PORTS*DATA_W]  port i byte at [i*DATA_W +: DATA_W]
//            req_ready [N_PORTS]         one-cycle consume pulse per port
//            din       [DATA_W]          byte to Transmitter
//            tr_start                    one-cycle launch pulse
//            tr_free                     Transmitter idle flag
// Modports : slave  - arbiter side
//            master - requesters + Transmitter side
// Revision : 1.0 - initial release
// ============================================================================
interface hub_tx_arbiter_if
  import hub_pkg::*;
#(
  parameter int N_PORTS = HUB_N_PORTS,
  parameter int DATA_W  = HUB_DATA_W
);

  logic [N_PORTS-1:0]        req_valid;
  logic [N_PORTS*DATA_W-1:0] req_data;
  logic [N_PORTS-1:0]        req_ready;
  logic [DATA_W-1:0]         din;
  logic                      tr_start;
  logic                      tr_free;

  modport slave (
    input  req_valid, req_data, tr_free,
    output req_ready, din, tr_start
  );

  modport master (
    output req_valid, req_data, tr_free,
    input  req_ready, din, tr_start
  );

endinterface
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin search. Returns the first asserted
//            request starting at (last+1) mod N_PORTS, wrapping around.
// Ports    : req     [N_PORTS]          request vector
//            last    [$clog2(N_PORTS)]  most recently granted port
//            gnt_idx [$clog2(N_PORTS)]  selected port (valid when any=1)
//            any                        at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N_PORTS = 4
) (
  input  logic [N_PORTS-1:0]         req,
  input  logic [$clog2(N_PORTS)-1:0] last,
  output logic [$clog2(N_PORTS)-1:0] gnt_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(N_PORTS);

  // Scan offsets from farthest to nearest so the nearest hit after 'last'
  // is the one left standing.
  always_comb begin
    logic [IDX_W-1:0] w_pos;
    w_pos   = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = N_PORTS; k >= 1; k--) begin
      w_pos = IDX_W'((int'(last) + k) % N_PORTS);
      if (req[w_pos]) begin
        gnt_idx = w_pos;
        any     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hub_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hub_tx_arbiter
// Purpose  : Round-robin arbiter sharing one Transmitter UART among N_PORTS
//            hub ports. Grants a port, launches its byte with a tr_start
//            pulse, then follows tr_free low (frame started) and high
//            (frame done) before granting again.
// Ports    : clk       single clock, rising edge
//            reset     synchronous, active-high
//            bus       hub_tx_arbiter_if.slave (requests + Transmitter pins)
//            busy      arbiter not idle
//            cur_port  port of last/current grant
//            err       one-cycle pulse: tr_free never dropped after launch
// Revision : 1.0 - initial release
// ============================================================================
module hub_tx_arbiter
  import hub_pkg::*;
#(
  parameter int N_PORTS     = HUB_N_PORTS,
  parameter int DATA_W      = HUB_DATA_W,
  parameter int LOW_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  hub_tx_arbiter_if.slave            bus,
  output logic                       busy,
  output logic [$clog2(N_PORTS)-1:0] cur_port,
  output logic                       err
);

  localparam int IDX_W  = $clog2(N_PORTS);
  localparam int TCNT_W = $clog2(LOW_TIMEOUT + 1);

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_last;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [DATA_W-1:0]   r_din;
  logic [IDX_W-1:0]    r_cur_port;
  logic [N_PORTS-1:0]  r_req_ready;
  logic                r_tr_start;
  logic                r_busy;
  logic                r_err;

  logic [IDX_W-1:0]    w_gnt_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_port_data [N_PORTS];
  logic [DATA_W-1:0]   w_sel_data;
  logic [TCNT_W-1:0]   w_tcnt_next;

  rr_picker #(
    .N_PORTS (N_PORTS)
  ) u_picker (
    .req     (bus.req_valid),
    .last    (r_last),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
    assign w_port_data[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  assign w_sel_data  = w_port_data[w_gnt_idx];
  assign w_tcnt_next = r_tcnt + TCNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= IDX_W'(N_PORTS - 1);
      r_tcnt      <= '0;
      r_din       <= '0;
      r_cur_port  <= '0;
      r_req_ready <= '0;
      r_tr_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Pulse outputs default low; only the grant / timeout edges raise them.
      r_tr_start  <= 1'b0;
      r_req_ready <= '0;
      r_err       <= 1'b0;
      case (r_state)
        IDLE: begin
          // tr_free low here means the Transmitter is still finishing a
          // frame, so requests are left waiting.
          if (bus.tr_free && w_any) begin
            r_state     <= WAIT_LOW;
            r_tcnt      <= '0;
            r_din       <= w_sel_data;
            r_cur_port  <= w_gnt_idx;
            r_last      <= w_gnt_idx;
            r_tr_start  <= 1'b1;
            r_req_ready <= N_PORTS'(1) << w_gnt_idx;
            r_busy      <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!bus.tr_free) begin
            r_state <= WAIT_HIGH;
          end else begin
            r_tcnt <= w_tcnt_next;
            if (w_tcnt_next == TCNT_W'(LOW_TIMEOUT)) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          if (bus.tr_free) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.din       = r_din;
  assign bus.tr_start  = r_tr_start;
  assign busy          = r_busy;
  assign cur_port      = r_cur_port;
  assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hub_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub_tx_arbiter
// Purpose  : Self-checking bench for hub_tx_arbiter: vector table, directed
//            corner sequences and a randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic       err;
  logic [1:0] cur_port;

  always #5 clk = ~clk;

  hub_tx_arbiter_if #(.N_PORTS(N), .DATA_W(W)) bus ();

  hub_tx_arbiter #(
    .N_PORTS     (N),
    .DATA_W      (W),
    .LOW_TIMEOUT (LT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .cur_port (cur_port),
    .err      (err)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Transmitter model: 0 normal, 1 stub stuck free, 2 forced not-free
  int         xmode;
  int         xcnt;
  bit         x_pend;
  int         frame_len;
  logic [7:0] tx_log[$];

  // Reference model state
  bit         m_busy, m_low;
  int         m_wait, m_last;
  logic       exp_ts, exp_err, exp_busy;
  logic [3:0] exp_rdy;
  logic [7:0] exp_din;
  logic [1:0] exp_cur;
  logic [7:0] exp_sent[$];

  // Requesters: 0 drop on ready, 1 keep offering, 2 random queues
  int         rq_mode;
  logic [3:0] prev_rdy;
  logic [7:0] pq[4][$];
  int         gap[4];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_port;
    logic [7:0]  exp_din;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int off = 1; off <= N; off++) begin
      if (v[2'((last + off) % N)]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_low = 0; m_wait = 0; m_last = N - 1;
    exp_ts = 0; exp_err = 0; exp_busy = 0; exp_rdy = '0;
    exp_din = '0; exp_cur = '0;
    prev_rdy = '0;
    xcnt = 0; x_pend = 0; bus.tr_free = 1'b1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.req_valid = '0;
    repeat (n) @(posedge clk);
    #1;
    cyc++;
    check("reset_outs", {busy, err, bus.tr_start, bus.req_ready, cur_port, bus.din}, 32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  // One clock: predict from the inputs present before the edge, compare
  // just after it, then let the Transmitter and requesters react.
  task automatic step();
    int g;
    exp_ts = 0; exp_rdy = '0; exp_err = 0;
    if (!m_busy) begin
      if (bus.tr_free && (bus.req_valid != 0)) begin
        g        = rr_pick(bus.req_valid, m_last);
        exp_ts   = 1;
        exp_rdy  = 4'(1 << g);
        exp_din  = bus.req_data[g*W +: W];
        exp_cur  = 2'(g);
        m_last   = g;
        m_busy   = 1; m_low = 0; m_wait = 0;
        exp_sent.push_back(exp_din);
      end
    end else if (!m_low) begin
      if (!bus.tr_free) m_low = 1;
      else begin
        m_wait++;
        if (m_wait == LT) begin exp_err = 1; m_busy = 0; end
      end
    end else if (bus.tr_free) begin
      m_busy = 0;
    end
    exp_busy = m_busy;

    @(posedge clk);
    #1;
    cyc++;
    check("ctl", {busy, err, bus.tr_start, bus.req_ready}, {exp_busy, exp_err, exp_ts, exp_rdy});
    check("data", {cur_port, bus.din}, {exp_cur, exp_din});

    case (xmode)
      0: begin
        if (x_pend) begin
          bus.tr_free = 1'b0;
          xcnt = frame_len;
          tx_log.push_back(bus.din);
        end else if (xcnt > 0) begin
          xcnt--;
          if (xcnt == 0) bus.tr_free = 1'b1;
        end
      end
      1: bus.tr_free = 1'b1;
      default: bus.tr_free = 1'b0;
    endcase
    x_pend = bus.tr_start;

    for (int i = 0; i < N; i++) begin
      if (prev_rdy[i]) begin
        if (rq_mode == 0) bus.req_valid[i] = 1'b0;
        else if (rq_mode == 2) begin
          void'(pq[i].pop_front());
          bus.req_valid[i] = 1'b0;
          gap[i] = $urandom_range(0, 3);
        end
      end
      if (rq_mode == 2 && !bus.req_valid[i] && pq[i].size() > 0) begin
        if (gap[i] > 0) gap[i]--;
        else begin
          bus.req_data[i*W +: W] = pq[i][0];
          bus.req_valid[i] = 1'b1;
        end
      end
    end
    prev_rdy = bus.req_ready;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && busy; t++) step();
    check("drain_idle", {31'b0, busy}, 32'h0);
    step();
  endtask

  initial begin
    int         found, s, rdy_seen, total, mism;
    logic [7:0] rr_seq[$];

    tbl[0] = '{4'b0100, 32'h0061_0000, 2'd2, 8'h61};
    tbl[1] = '{4'b1111, 32'hA3A2_A1A0, 2'd3, 8'hA3};
    tbl[2] = '{4'b1010, 32'hB3B2_B1B0, 2'd1, 8'hB1};
    tbl[3] = '{4'b1011, 32'hC3C2_C1C0, 2'd3, 8'hC3};
    tbl[4] = '{4'b0001, 32'hD3D2_D1D0, 2'd0, 8'hD0};
    tbl[5] = '{4'b1111, 32'hE3E2_E1E0, 2'd1, 8'hE1};
    tbl[6] = '{4'b0001, 32'hF3F2_F1F0, 2'd0, 8'hF0};
    tbl[7] = '{4'b1000, 32'h1312_1110, 2'd3, 8'h13};

    xmode = 0; rq_mode = 0; frame_len = 6;
    bus.req_valid = '0; bus.req_data = '0; bus.tr_free = 1'b1;
    model_reset();
    do_reset(10);

    // Vector table: each row is one grant starting from idle.
    for (int r = 0; r < 8; r++) begin
      bus.req_data  = tbl[r].data;
      bus.req_valid = tbl[r].valid;
      found = 0;
      for (int t = 0; t < 20 && found == 0; t++) begin
        step();
        if (bus.tr_start) found = 1;
      end
      check("tbl_grant_seen", found, 1);
      check("tbl_port", {30'b0, cur_port}, {30'b0, tbl[r].exp_port});
      check("tbl_din", {24'b0, bus.din}, {24'b0, tbl[r].exp_din});
      check("tbl_ready", {28'b0, bus.req_ready}, 32'(1 << tbl[r].exp_port));
      bus.req_valid = '0;
      drain();
    end

    // Round robin with every port continuously offering.
    do_reset(2);
    rq_mode = 1;
    bus.req_data  = 32'h1312_1110;
    bus.req_valid = 4'b1111;
    for (int t = 0; t < 200 && rr_seq.size() < 5; t++) begin
      step();
      if (bus.tr_start) rr_seq.push_back(bus.din);
    end
    check("rr_count", rr_seq.size(), 5);
    for (int k = 0; k < rr_seq.size() && k < 5; k++)
      check("rr_order", {24'b0, rr_seq[k]}, 32'h10 + 32'(k % 4));
    bus.req_valid = '0;
    rq_mode = 0;
    drain();

    // Idle with Transmitter not free: request must wait.
    xmode = 2; bus.tr_free = 1'b0;
    bus.req_data = 32'h0000_0077; bus.req_valid = 4'b0001;
    found = 0;
    for (int t = 0; t < 5; t++) begin
      step();
      if (bus.tr_start || bus.req_ready != 0) found = 1;
    end
    check("blocked_no_grant", found, 0);
    xmode = 0; bus.tr_free = 1'b1;
    step();
    check("blocked_then_grant", {31'b0, bus.tr_start}, 32'h1);
    check("blocked_din", {24'b0, bus.din}, 32'h77);
    drain();

    // Timeout: Transmitter never drops tr_free.
    xmode = 1;
    bus.req_data = 32'h0000_5500; bus.req_valid = 4'b0010;
    s = -1;
    for (int t = 0; t < 20 && s < 0; t++) begin
      step();
      if (bus.tr_start) s = cyc;
    end
    check("to_start_seen", {31'b0, s >= 0}, 32'h1);
    found = 0;
    for (int t = 0; t < 10 && found == 0; t++) begin
      step();
      if (err) found = cyc;
    end
    check("to_err_latency", found - s, LT);
    check("to_busy_low", {31'b0, busy}, 32'h0);
    rdy_seen = 0;
    for (int t = 0; t < 5; t++) begin
      step();
      if (bus.req_ready != 0 || err) rdy_seen = 1;
    end
    check("to_no_second", rdy_seen, 0);
    xmode = 0;

    // Reset while in the middle of a frame.
    bus.req_data = 32'h0044_0000; bus.req_valid = 4'b0100;
    found = 0;
    for (int t = 0; t < 20 && found == 0; t++) begin
      step();
      if (busy && !bus.tr_free) found = 1;
    end
    step();
    check("mid_in_frame", {30'b0, busy, bus.tr_free}, 32'h2);
    do_reset(1);
    bus.req_data = 32'h00AA_00BB; bus.req_valid = 4'b0101;
    found = 0;
    for (int t = 0; t < 10 && found == 0; t++) begin
      step();
      if (bus.tr_start) found = 1;
    end
    check("mid_post_port0", {29'b0, found[0], cur_port}, 32'h4);
    drain();
    bus.req_valid = '0;
    drain();

    // Randomized traffic with random frame lengths.
    do_reset(2);
    tx_log.delete(); exp_sent.delete();
    rq_mode = 2; total = 0;
    for (int i = 0; i < N; i++) begin
      int n;
      n = $urandom_range(2, 6);
      for (int j = 0; j < n; j++) pq[i].push_back(8'($urandom));
      gap[i] = $urandom_range(0, 3);
      total += n;
    end
    found = 0;
    for (int t = 0; t < 3000 && found == 0; t++) begin
      if (x_pend) frame_len = $urandom_range(1, 8);
      step();
      if (pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() == 0 &&
          !busy && bus.tr_free && bus.req_valid == 0) found = 1;
    end
    check("rnd_done", found, 1);
    check("rnd_model_count", exp_sent.size(), total);
    check("rnd_tx_count", tx_log.size(), total);
    mism = 0;
    for (int k = 0; k < tx_log.size() && k < exp_sent.size(); k++)
      if (tx_log[k] !== exp_sent[k]) mism++;
    check("rnd_stream", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
